// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline constants and decode control bundle layout
// Purpose : field positions of the packed decode control bundle, bundle width,
//           the NOP instruction word and register-field helpers.
// Ports   : none (package).
package pipe_pkg;

  localparam int CTRL_W   = 40;
  localparam int REG_W    = 5;
  localparam int WORD_W   = 32;

  // Control bundle bit positions (bit 0 = LSB of id_ctrl / ex_ctrl).
  localparam int ALUOP_LSB = 0;
  localparam int ALUOP_W   = 4;
  localparam int ALUSRC    = 4;
  localparam int MEMWRITE  = 5;
  localparam int B         = 6;
  localparam int JR        = 7;
  localparam int JMP       = 8;
  localparam int JAL       = 9;
  localparam int ERET      = 10;
  localparam int SYSCALL   = 11;

  localparam logic [WORD_W-1:0] NOP_IR = 32'h0000_0000;

  function automatic logic [REG_W-1:0] ir_rs(input logic [WORD_W-1:0] ir);
    return ir[25:21];
  endfunction

  function automatic logic [REG_W-1:0] ir_rt(input logic [WORD_W-1:0] ir);
    return ir[20:16];
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use and HI/LO interlock detection
// Purpose : flags when the instruction in decode must wait one cycle behind the
//           instruction currently in execute.
// Ports   : id_valid, id_rs, id_rt, id_r1_used, id_r2_used, id_hi_used, id_lo_used
//           (decode side); ex_valid, ex_memtoreg, ex_hilowrite, ex_wreg (execute side);
//           lu, hl, haz outputs.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_r1_used,
  input  logic             id_r2_used,
  input  logic             id_hi_used,
  input  logic             id_lo_used,
  input  logic             ex_valid,
  input  logic             ex_memtoreg,
  input  logic             ex_hilowrite,
  input  logic [REG_W-1:0] ex_wreg,
  output logic             lu,
  output logic             hl,
  output logic             haz
);

  // $0 is hardwired, so a load targeting it never produces a real dependency.
  assign lu  = id_valid & ex_valid & ex_memtoreg & (ex_wreg != '0) &
               ((id_r1_used & (id_rs == ex_wreg)) | (id_r2_used & (id_rt == ex_wreg)));
  assign hl  = id_valid & ex_valid & ex_hilowrite & (id_hi_used | id_lo_used);
  assign haz = lu | hl;

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with hazard interlock and bubble counter
// Purpose : registers the decode bundle for execute, inserts bubbles on load-use and
//           HI/LO hazards, obeys EX flush and stall, counts inserted hazard bubbles.
// Ports   : clk, rst (sync, active-high); id_* decode inputs; ex_flush, ex_stall;
//           ex_* registered outputs; stall_id (combinational); bubble_cnt (saturating).
module id_ex_stage #(
  parameter int CTRL_W = pipe_pkg::CTRL_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [31:0]       id_pc,
  input  logic [31:0]       id_ir,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [31:0]       id_r1,
  input  logic [31:0]       id_r2,
  input  logic              id_r1_used,
  input  logic              id_r2_used,
  input  logic              id_hi_used,
  input  logic              id_lo_used,
  input  logic [4:0]        id_wreg,
  input  logic              id_regwrite,
  input  logic              id_memtoreg,
  input  logic              id_hilowrite,
  input  logic              ex_flush,
  input  logic              ex_stall,
  output logic              ex_valid,
  output logic [31:0]       ex_pc,
  output logic [31:0]       ex_ir,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [31:0]       ex_r1,
  output logic [31:0]       ex_r2,
  output logic [4:0]        ex_wreg,
  output logic              ex_regwrite,
  output logic              ex_memtoreg,
  output logic              ex_hilowrite,
  output logic              stall_id,
  output logic [CNT_W-1:0]  bubble_cnt
);

  import pipe_pkg::*;

  logic lu;
  logic hl;
  logic haz;
  logic advance;
  logic load_id;

  hazard_detect u_hazard_detect (
    .id_valid     (id_valid),
    .id_rs        (ir_rs(id_ir)),
    .id_rt        (ir_rt(id_ir)),
    .id_r1_used   (id_r1_used),
    .id_r2_used   (id_r2_used),
    .id_hi_used   (id_hi_used),
    .id_lo_used   (id_lo_used),
    .ex_valid     (ex_valid),
    .ex_memtoreg  (ex_memtoreg),
    .ex_hilowrite (ex_hilowrite),
    .ex_wreg      (ex_wreg),
    .lu           (lu),
    .hl           (hl),
    .haz          (haz)
  );

  // A flush kills decode as well, so it must not freeze the front end.
  assign stall_id = ~ex_flush & (ex_stall | haz);

  // The register updates on flush or when not stalled; it takes the decode slot only
  // when nothing forces a bubble, otherwise it loads an all-zero payload.
  assign advance = ex_flush | ~ex_stall;
  assign load_id = ~ex_flush & ~ex_stall & ~haz & id_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_ir        <= NOP_IR;
      ex_ctrl      <= '0;
      ex_r1        <= '0;
      ex_r2        <= '0;
      ex_wreg      <= '0;
      ex_regwrite  <= 1'b0;
      ex_memtoreg  <= 1'b0;
      ex_hilowrite <= 1'b0;
    end else if (advance) begin
      ex_valid     <= load_id;
      ex_pc        <= load_id ? id_pc   : '0;
      ex_ir        <= load_id ? id_ir   : NOP_IR;
      ex_ctrl      <= load_id ? id_ctrl : '0;
      ex_r1        <= load_id ? id_r1   : '0;
      ex_r2        <= load_id ? id_r2   : '0;
      ex_wreg      <= load_id ? id_wreg : '0;
      ex_regwrite  <= load_id & id_regwrite;
      ex_memtoreg  <= load_id & id_memtoreg;
      ex_hilowrite <= load_id & id_hilowrite;
    end
  end

  // Only hazard bubbles count; flush and stall cycles are attributed elsewhere.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (~ex_flush & ~ex_stall & haz & (bubble_cnt != {CNT_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

  logic unused_hl_lu;
  assign unused_hl_lu = lu ^ hl;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_pc, id_ir, id_r1, id_r2;
  logic [39:0] id_ctrl;
  logic        id_r1_used, id_r2_used, id_hi_used, id_lo_used;
  logic [4:0]  id_wreg;
  logic        id_regwrite, id_memtoreg, id_hilowrite;
  logic        ex_flush, ex_stall;

  logic        ex_valid, ex_regwrite, ex_memtoreg, ex_hilowrite, stall_id;
  logic [31:0] ex_pc, ex_ir, ex_r1, ex_r2;
  logic [39:0] ex_ctrl;
  logic [4:0]  ex_wreg;
  logic [15:0] bubble_cnt;

  logic        s_ex_valid, s_ex_regwrite, s_ex_memtoreg, s_ex_hilowrite, s_stall_id;
  logic [31:0] s_ex_pc, s_ex_ir, s_ex_r1, s_ex_r2;
  logic [39:0] s_ex_ctrl;
  logic [4:0]  s_ex_wreg;
  logic [1:0]  s_bubble_cnt;

  int checks = 0;
  int passes = 0;

  localparam logic [31:0] LW8   = 32'h8D28_0000;
  localparam logic [31:0] LW0   = 32'h8D20_0000;
  localparam logic [31:0] ADD9  = 32'h010A_4820;
  localparam logic [31:0] ADDZ  = 32'h000A_4820;
  localparam logic [31:0] MULTU = 32'h0085_0019;
  localparam logic [31:0] MFLO  = 32'h0000_3012;
  localparam logic [31:0] ADDU  = 32'h0085_3821;
  localparam logic [39:0] C_LW  = 40'h00_0000_0011;
  localparam logic [39:0] C_ADD = 40'h00_0000_0002;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_ir(id_ir),
    .id_ctrl(id_ctrl), .id_r1(id_r1), .id_r2(id_r2), .id_r1_used(id_r1_used),
    .id_r2_used(id_r2_used), .id_hi_used(id_hi_used), .id_lo_used(id_lo_used),
    .id_wreg(id_wreg), .id_regwrite(id_regwrite), .id_memtoreg(id_memtoreg),
    .id_hilowrite(id_hilowrite), .ex_flush(ex_flush), .ex_stall(ex_stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_ir(ex_ir), .ex_ctrl(ex_ctrl),
    .ex_r1(ex_r1), .ex_r2(ex_r2), .ex_wreg(ex_wreg), .ex_regwrite(ex_regwrite),
    .ex_memtoreg(ex_memtoreg), .ex_hilowrite(ex_hilowrite), .stall_id(stall_id),
    .bubble_cnt(bubble_cnt)
  );

  id_ex_stage #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_ir(id_ir),
    .id_ctrl(id_ctrl), .id_r1(id_r1), .id_r2(id_r2), .id_r1_used(id_r1_used),
    .id_r2_used(id_r2_used), .id_hi_used(id_hi_used), .id_lo_used(id_lo_used),
    .id_wreg(id_wreg), .id_regwrite(id_regwrite), .id_memtoreg(id_memtoreg),
    .id_hilowrite(id_hilowrite), .ex_flush(ex_flush), .ex_stall(ex_stall),
    .ex_valid(s_ex_valid), .ex_pc(s_ex_pc), .ex_ir(s_ex_ir), .ex_ctrl(s_ex_ctrl),
    .ex_r1(s_ex_r1), .ex_r2(s_ex_r2), .ex_wreg(s_ex_wreg), .ex_regwrite(s_ex_regwrite),
    .ex_memtoreg(s_ex_memtoreg), .ex_hilowrite(s_ex_hilowrite), .stall_id(s_stall_id),
    .bubble_cnt(s_bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [31:0] ir,
                        input logic [39:0] ctrl, input logic r1u, input logic r2u,
                        input logic hiu, input logic lou, input logic [4:0] wreg,
                        input logic rw, input logic m2r, input logic hlw);
    id_valid = v; id_pc = pc; id_ir = ir; id_ctrl = ctrl;
    id_r1 = pc ^ 32'h1111_1111; id_r2 = pc ^ 32'h2222_2222;
    id_r1_used = r1u; id_r2_used = r2u; id_hi_used = hiu; id_lo_used = lou;
    id_wreg = wreg; id_regwrite = rw; id_memtoreg = m2r; id_hilowrite = hlw;
  endtask

  task automatic set_idle;
    set_id(1'b0, 32'h0, 32'h0, 40'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    rst = 1'b1; ex_flush = 1'b0; ex_stall = 1'b0;
    set_id(1'b1, 32'h400, LW8, C_LW, 1'b1, 1'b0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
    tick; tick;
    checks++; if (ex_valid !== 1'b0) $display("FAIL reset_ex_valid got %0b want 0", ex_valid); else passes++;
    checks++; if (ex_ctrl !== 40'h0) $display("FAIL reset_ex_ctrl got %h want 0", ex_ctrl); else passes++;
    checks++; if (ex_ir !== 32'h0) $display("FAIL reset_ex_ir got %h want 0", ex_ir); else passes++;
    checks++; if (bubble_cnt !== 16'd0) $display("FAIL reset_bubble_cnt got %0d want 0", bubble_cnt); else passes++;
    checks++; if (stall_id !== 1'b0) $display("FAIL reset_stall_id got %0b want 0", stall_id); else passes++;
    checks++; if (ex_regwrite !== 1'b0) $display("FAIL reset_ex_regwrite got %0b want 0", ex_regwrite); else passes++;
    rst = 1'b0;
    set_idle;
    tick;
  endtask

  task automatic test_load_use;
    set_id(1'b1, 32'h100, LW8, C_LW, 1'b1, 1'b0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
    tick;
    checks++; if (ex_valid !== 1'b1 || ex_ir !== LW8 || ex_ctrl !== C_LW)
      $display("FAIL lu_edge1 got v=%0b ir=%h ctrl=%h want 1 %h %h", ex_valid, ex_ir, ex_ctrl, LW8, C_LW); else passes++;
    checks++; if (ex_r1 !== (32'h100 ^ 32'h1111_1111)) $display("FAIL lu_edge1_r1 got %h want %h", ex_r1, 32'h100 ^ 32'h1111_1111); else passes++;
    set_id(1'b1, 32'h104, ADD9, C_ADD, 1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
    #1;
    checks++; if (stall_id !== 1'b1) $display("FAIL lu_stall_id got %0b want 1", stall_id); else passes++;
    tick;
    checks++; if (ex_valid !== 1'b0 || ex_ir !== 32'h0 || ex_regwrite !== 1'b0)
      $display("FAIL lu_bubble got v=%0b ir=%h rw=%0b want 0 0 0", ex_valid, ex_ir, ex_regwrite); else passes++;
    checks++; if (stall_id !== 1'b0) $display("FAIL lu_stall_release got %0b want 0", stall_id); else passes++;
    checks++; if (bubble_cnt !== 16'd1) $display("FAIL lu_bubble_cnt got %0d want 1", bubble_cnt); else passes++;
    tick;
    checks++; if (ex_valid !== 1'b1 || ex_ir !== ADD9 || ex_pc !== 32'h104 || ex_wreg !== 5'd9)
      $display("FAIL lu_add_in_ex got v=%0b ir=%h pc=%h wreg=%0d want 1 %h 104 9", ex_valid, ex_ir, ex_pc, ex_wreg, ADD9); else passes++;
    set_idle;
    tick;
  endtask

  task automatic test_load_use_r0;
    set_id(1'b1, 32'h200, LW0, C_LW, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    tick;
    set_id(1'b1, 32'h204, ADDZ, C_ADD, 1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
    #1;
    checks++; if (stall_id !== 1'b0) $display("FAIL r0_stall_id got %0b want 0", stall_id); else passes++;
    tick;
    checks++; if (ex_valid !== 1'b1 || ex_ir !== ADDZ) $display("FAIL r0_add_next got v=%0b ir=%h want 1 %h", ex_valid, ex_ir, ADDZ); else passes++;
    checks++; if (bubble_cnt !== 16'd1) $display("FAIL r0_bubble_cnt got %0d want 1", bubble_cnt); else passes++;
    set_idle;
    tick;
  endtask

  task automatic test_hilo;
    set_id(1'b1, 32'h300, MULTU, C_ADD, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    tick;
    checks++; if (ex_hilowrite !== 1'b1) $display("FAIL hl_multu_in_ex got %0b want 1", ex_hilowrite); else passes++;
    set_id(1'b1, 32'h304, MFLO, C_ADD, 1'b0, 1'b0, 1'b0, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    #1;
    checks++; if (stall_id !== 1'b1) $display("FAIL hl_stall_id got %0b want 1", stall_id); else passes++;
    tick;
    checks++; if (ex_valid !== 1'b0 || ex_hilowrite !== 1'b0) $display("FAIL hl_bubble got v=%0b hlw=%0b want 0 0", ex_valid, ex_hilowrite); else passes++;
    checks++; if (bubble_cnt !== 16'd2) $display("FAIL hl_bubble_cnt got %0d want 2", bubble_cnt); else passes++;
    tick;
    checks++; if (ex_valid !== 1'b1 || ex_ir !== MFLO) $display("FAIL hl_mflo_in_ex got v=%0b ir=%h want 1 %h", ex_valid, ex_ir, MFLO); else passes++;
    set_id(1'b1, 32'h308, ADDU, C_ADD, 1'b1, 1'b1, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
    tick;
    set_id(1'b1, 32'h30C, MFLO, C_ADD, 1'b0, 1'b0, 1'b0, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    #1;
    checks++; if (stall_id !== 1'b0) $display("FAIL hl_after_addu_stall got %0b want 0", stall_id); else passes++;
    tick;
    checks++; if (bubble_cnt !== 16'd2 || ex_ir !== MFLO) $display("FAIL hl_after_addu got cnt=%0d ir=%h want 2 %h", bubble_cnt, ex_ir, MFLO); else passes++;
    set_idle;
    tick;
  endtask

  task automatic test_flush;
    set_id(1'b1, 32'h500, LW8, C_LW, 1'b1, 1'b0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
    tick;
    set_id(1'b1, 32'h504, ADD9, C_ADD, 1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
    ex_flush = 1'b1; ex_stall = 1'b1;
    #1;
    checks++; if (stall_id !== 1'b0) $display("FAIL flush_stall_id got %0b want 0", stall_id); else passes++;
    tick;
    checks++; if (ex_valid !== 1'b0 || ex_ctrl !== 40'h0 || ex_memtoreg !== 1'b0)
      $display("FAIL flush_bubble got v=%0b ctrl=%h m2r=%0b want 0 0 0", ex_valid, ex_ctrl, ex_memtoreg); else passes++;
    checks++; if (bubble_cnt !== 16'd2) $display("FAIL flush_bubble_cnt got %0d want 2", bubble_cnt); else passes++;
    ex_flush = 1'b0; ex_stall = 1'b0;
    set_idle;
    tick;
  endtask

  task automatic test_stall;
    set_id(1'b1, 32'h600, LW8, C_LW, 1'b1, 1'b0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
    tick;
    ex_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, 32'h700 + 32'(i * 4), ADD9 + 32'(i), C_ADD, 1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
      #1;
      checks++; if (stall_id !== 1'b1) $display("FAIL stall_id_%0d got %0b want 1", i, stall_id); else passes++;
      tick;
      checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h600 || ex_ir !== LW8 || ex_r1 !== (32'h600 ^ 32'h1111_1111) || ex_wreg !== 5'd8)
        $display("FAIL stall_hold_%0d got v=%0b pc=%h ir=%h r1=%h wreg=%0d want 1 600 %h %h 8", i, ex_valid, ex_pc, ex_ir, ex_r1, ex_wreg, LW8, 32'h600 ^ 32'h1111_1111); else passes++;
      checks++; if (bubble_cnt !== 16'd2) $display("FAIL stall_cnt_%0d got %0d want 2", i, bubble_cnt); else passes++;
    end
    ex_stall = 1'b0;
    tick;
    checks++; if (ex_valid !== 1'b0 || bubble_cnt !== 16'd3) $display("FAIL stall_release got v=%0b cnt=%0d want 0 3", ex_valid, bubble_cnt); else passes++;
    set_idle;
    tick;
  endtask

  task automatic test_saturate;
    logic [1:0] exp_sat;
    ex_stall = 1'b1;
    rst = 1'b1;
    tick;
    rst = 1'b0; ex_stall = 1'b0;
    #1;
    checks++; if (stall_id !== 1'b0 || s_bubble_cnt !== 2'd0 || bubble_cnt !== 16'd0)
      $display("FAIL rst_mid_stall got stall=%0b sat=%0d cnt=%0d want 0 0 0", stall_id, s_bubble_cnt, bubble_cnt); else passes++;
    for (int i = 0; i < 5; i++) begin
      exp_sat = (i >= 2) ? 2'd3 : 2'(i + 1);
      set_id(1'b1, 32'h800, LW8, C_LW, 1'b1, 1'b0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
      tick;
      set_id(1'b1, 32'h804, ADD9, C_ADD, 1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
      tick;
      checks++; if (s_bubble_cnt !== exp_sat) $display("FAIL sat_cnt_%0d got %0d want %0d", i, s_bubble_cnt, exp_sat); else passes++;
      checks++; if (bubble_cnt !== 16'(i + 1)) $display("FAIL wide_cnt_%0d got %0d want %0d", i, bubble_cnt, i + 1); else passes++;
      tick;
    end
    set_idle;
    tick;
  endtask

  initial begin
    rst = 1'b1; ex_flush = 1'b0; ex_stall = 1'b0;
    set_idle;
    test_reset;
    test_load_use;
    test_load_use_r0;
    test_hilo;
    test_flush;
    test_stall;
    test_saturate;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
